cmp_seq_unit: RTL and testbench
===============================

CMP_SEQ_UNIT -- requirements
Module: cmp_seq_unit

Interface
REQ-001 Parameter Data_In_Width, default 16, operand width in bits; SHALL be an integer multiple of Slice_Width.
REQ-002 Parameter Slice_Width, default 4, bits compared per cycle; NUM_SLICES = Data_In_Width/Slice_Width.
REQ-003 CLK_in  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST_in  input  1  reset, asynchronous, active-low.
REQ-005 A_in  input  Data_In_Width  operand A.
REQ-006 B_in  input  Data_In_Width  operand B.
REQ-007 alu_fun  input  4  operation select; only bits [2:0] are used.
REQ-008 signed_en  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-009 cmp_En  input  1  start request, sampled only in IDLE.
REQ-010 busy  output  1  high while state is not IDLE.
REQ-011 cmp_done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
REQ-012 cmp_out  output  2  relation code: 00 none, 01 A==B, 10 A>B, 11 A<B.
REQ-013 cmp_flag  output  1  predicate result of the selected operation.
REQ-014 sel_out  output  Data_In_Width  operand selected by MAX/MIN, else 0.

Function
REQ-015 Opcodes alu_fun[2:0] SHALL be: 000 NOP, 001 EQ, 010 GT, 011 LT, 100 GE, 101 LE, 110 MAX, 111 MIN.
REQ-016 FSM states SHALL be IDLE, SCAN, DONE; reset state IDLE.
REQ-017 IDLE with cmp_En=1 at edge E0: A_in, B_in, alu_fun[2:0], signed_en SHALL be latched; next state SCAN with slice index NUM_SLICES-1, or DONE if opcode is NOP.
REQ-018 Inputs changing after E0 SHALL NOT affect the operation in progress.
REQ-019 SCAN: one slice per edge, MSB slice first; in signed mode the operand sign bits SHALL be inverted before comparing the top slice, all slices then compared unsigned.
REQ-020 SCAN early termination: first unequal slice decides GT or LT and next state SHALL be DONE; equal slice at index 0 decides EQ, next DONE; otherwise index decrements.
REQ-021 DONE edge: cmp_out, cmp_flag, sel_out SHALL update, cmp_done SHALL be 1 for the following cycle only, next state IDLE.
REQ-022 Latency: with m slices examined (1..NUM_SLICES, 0 for NOP), results and cmp_done SHALL appear after edge E(m+1); busy SHALL be high after E0 through the cycle before that edge.
REQ-023 cmp_flag: EQ = A==B; GT = A>B; LT = A<B; GE = !(A<B); LE = !(A>B); MAX = 1 if A selected; MIN = 1 if A selected; NOP = 0.
REQ-024 sel_out: MAX = larger operand, MIN = smaller operand, A when equal; all other opcodes 0.
REQ-025 NOP SHALL produce cmp_out=00, cmp_flag=0, sel_out=0.
REQ-026 cmp_En while busy SHALL be ignored and SHALL NOT be queued; the earliest new accept is the edge after the cmp_done cycle.
REQ-027 Results SHALL hold until the next DONE edge or reset.
REQ-028 An opcode with alu_fun[3]=1 SHALL behave identically to the same alu_fun[2:0] with alu_fun[3]=0.

Reset
REQ-029 RST_in low SHALL immediately force state IDLE, busy=0, cmp_done=0, cmp_out=00, cmp_flag=0, sel_out=0, and clear all latched operands.
REQ-030 Reset during SCAN or DONE SHALL abandon the operation with no cmp_done pulse; the first cmp_En after release SHALL run normally.

Verification (Data_In_Width=16, Slice_Width=4)
REQ-031 Unsigned EQ, A=B=0x1234 -> 4 slices scanned, cmp_done after E5, cmp_out=01, cmp_flag=1, sel_out=0.
REQ-032 GT, A=0x0001, B=0xFFFF -> signed: done after E2, cmp_out=10, cmp_flag=1; unsigned: done after E2, cmp_out=11, cmp_flag=0.
REQ-033 Signed MAX, A=0x8000, B=0x7FFF -> cmp_out=11, sel_out=0x7FFF, cmp_flag=0; MIN on the same operands -> sel_out=0x8000, cmp_flag=1.
REQ-034 GE and LE, A=B=0xFFFF signed -> cmp_out=01, cmp_flag=1 for both; NOP -> done after E1 with all outputs 0.
REQ-035 cmp_En pulsed and A_in/B_in changed mid-SCAN -> no effect on result, exactly one cmp_done pulse.
REQ-036 RST_in low for 1 cycle during SCAN -> all outputs 0 asynchronously, no cmp_done; next unsigned LT A=0x0010, B=0x0020 -> done after E4, cmp_out=11, cmp_flag=1.

Source files
------------

// File: rtl/cmp_seq_unit.sv
// Sequential magnitude comparator: scans operands one slice per cycle, MSB slice first,
// stopping at the first unequal slice, then reports relation, predicate and MAX/MIN select.
module cmp_seq_unit #(
    parameter int Data_In_Width = 16,
    parameter int Slice_Width   = 4
) (
    input  logic                     CLK_in,
    input  logic                     RST_in,
    input  logic [Data_In_Width-1:0] A_in,
    input  logic [Data_In_Width-1:0] B_in,
    input  logic [3:0]               alu_fun,
    input  logic                     signed_en,
    input  logic                     cmp_En,
    output logic                     busy,
    output logic                     cmp_done,
    output logic [1:0]               cmp_out,
    output logic                     cmp_flag,
    output logic [Data_In_Width-1:0] sel_out
);

    localparam int NUM_SLICES = Data_In_Width / Slice_Width;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_SLICES - 1);

    localparam logic [1:0] REL_NONE = 2'b00;
    localparam logic [1:0] REL_EQ   = 2'b01;
    localparam logic [1:0] REL_GT   = 2'b10;
    localparam logic [1:0] REL_LT   = 2'b11;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_EQ  = 3'd1;
    localparam logic [2:0] OP_GT  = 3'd2;
    localparam logic [2:0] OP_LT  = 3'd3;
    localparam logic [2:0] OP_GE  = 3'd4;
    localparam logic [2:0] OP_LE  = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd6;
    localparam logic [2:0] OP_MIN = 3'd7;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [Data_In_Width-1:0] r_a;
    logic [Data_In_Width-1:0] r_b;
    logic [2:0]               r_op;
    logic                     r_signed;
    logic [IDX_W-1:0]         r_idx;
    logic [1:0]               r_rel;
    logic                     r_done;
    logic [1:0]               r_cmp_out;
    logic                     r_cmp_flag;
    logic [Data_In_Width-1:0] r_sel_out;
    logic [Slice_Width-1:0]   w_sa;
    logic [Slice_Width-1:0]   w_sb;
    logic                     w_flag;
    logic [Data_In_Width-1:0] w_sel;
    logic                     w_unused;

    // The opcode's top bit is a don't-care.
    assign w_unused = alu_fun[3];

    // Flipping both sign bits of the top slice turns a signed compare into an unsigned one.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int k = 0; k < NUM_SLICES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sa = r_a[k*Slice_Width +: Slice_Width];
                w_sb = r_b[k*Slice_Width +: Slice_Width];
            end
        end
        if (r_signed && (r_idx == TOP_IDX)) begin
            w_sa[Slice_Width-1] = ~w_sa[Slice_Width-1];
            w_sb[Slice_Width-1] = ~w_sb[Slice_Width-1];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (cmp_En) w_next = (alu_fun[2:0] == OP_NOP) ? DONE : SCAN;
            SCAN: if ((w_sa != w_sb) || (r_idx == '0)) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_flag = 1'b0;
        w_sel  = '0;
        case (r_op)
            OP_EQ: w_flag = (r_rel == REL_EQ);
            OP_GT: w_flag = (r_rel == REL_GT);
            OP_LT: w_flag = (r_rel == REL_LT);
            OP_GE: w_flag = (r_rel != REL_LT);
            OP_LE: w_flag = (r_rel != REL_GT);
            OP_MAX: begin
                w_flag = (r_rel != REL_LT);
                w_sel  = (r_rel == REL_LT) ? r_b : r_a;
            end
            OP_MIN: begin
                w_flag = (r_rel != REL_GT);
                w_sel  = (r_rel == REL_GT) ? r_b : r_a;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK_in or negedge RST_in) begin
        if (!RST_in) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_ff @(posedge CLK_in or negedge RST_in) begin
        if (!RST_in) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_NOP;
            r_signed   <= 1'b0;
            r_idx      <= '0;
            r_rel      <= REL_NONE;
            r_done     <= 1'b0;
            r_cmp_out  <= REL_NONE;
            r_cmp_flag <= 1'b0;
            r_sel_out  <= '0;
        end else begin
            r_done <= (r_state == DONE);
            case (r_state)
                IDLE: if (cmp_En) begin
                    r_a      <= A_in;
                    r_b      <= B_in;
                    r_op     <= alu_fun[2:0];
                    r_signed <= signed_en;
                    r_idx    <= TOP_IDX;
                    r_rel    <= REL_NONE;
                end
                SCAN: begin
                    if (w_sa > w_sb)      r_rel <= REL_GT;
                    else if (w_sa < w_sb) r_rel <= REL_LT;
                    else if (r_idx == '0) r_rel <= REL_EQ;
                    else                  r_idx <= r_idx - IDX_W'(1);
                end
                DONE: begin
                    r_cmp_out  <= r_rel;
                    r_cmp_flag <= w_flag;
                    r_sel_out  <= w_sel;
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != IDLE);
    assign cmp_done = r_done;
    assign cmp_out  = r_cmp_out;
    assign cmp_flag = r_cmp_flag;
    assign sel_out  = r_sel_out;

endmodule

// File: tb/tb_cmp_seq_unit.sv
// Bench for cmp_seq_unit: directed vector table, randomized ops against a reference model,
// and hand sequences for mid-scan input changes and reset during a scan.
module tb_cmp_seq_unit;

    logic        CLK_in = 1'b0;
    logic        RST_in;
    logic [15:0] A_in;
    logic [15:0] B_in;
    logic [3:0]  alu_fun;
    logic        signed_en;
    logic        cmp_En;
    logic        busy;
    logic        cmp_done;
    logic [1:0]  cmp_out;
    logic        cmp_flag;
    logic [15:0] sel_out;

    int errors = 0;
    int checks = 0;

    cmp_seq_unit #(.Data_In_Width(16), .Slice_Width(4)) dut (
        .CLK_in(CLK_in), .RST_in(RST_in), .A_in(A_in), .B_in(B_in),
        .alu_fun(alu_fun), .signed_en(signed_en), .cmp_En(cmp_En),
        .busy(busy), .cmp_done(cmp_done), .cmp_out(cmp_out),
        .cmp_flag(cmp_flag), .sel_out(sel_out)
    );

    always #5 CLK_in = ~CLK_in;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic        sgn;
        int          lat;
        logic [1:0]  out;
        logic        flag;
        logic [15:0] sel;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: relation from whole-word arithmetic; slices examined from the highest differing bit.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         input logic sgn, output int lat, output logic [1:0] out,
                         output logic flag, output logic [15:0] sel);
        logic [15:0] d;
        int hb;
        logic gt, lt, eq;
        d  = a ^ b;
        hb = -1;
        for (int k = 0; k < 16; k++) if (d[k]) hb = k;
        eq = (a == b);
        gt = sgn ? ($signed(a) > $signed(b)) : (a > b);
        lt = !eq && !gt;
        lat  = (op == 3'd0) ? 1 : ((hb < 0) ? 5 : (4 - hb / 4) + 1);
        out  = (op == 3'd0) ? 2'b00 : (eq ? 2'b01 : (gt ? 2'b10 : 2'b11));
        flag = 1'b0;
        sel  = 16'h0;
        case (op)
            3'd1: flag = eq;
            3'd2: flag = gt;
            3'd3: flag = lt;
            3'd4: flag = !lt;
            3'd5: flag = !gt;
            3'd6: begin sel = lt ? b : a; flag = !lt; end
            3'd7: begin sel = gt ? b : a; flag = !gt; end
            default: ;
        endcase
    endtask

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] fun, input logic sgn);
        @(negedge CLK_in);
        A_in = a; B_in = b; alu_fun = fun; signed_en = sgn; cmp_En = 1'b1;
        @(posedge CLK_in);
        #1 cmp_En = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [3:0] fun, input logic sgn, input int e_lat,
                             input logic [1:0] e_out, input logic e_flag, input logic [15:0] e_sel);
        int cycles;
        logic [1:0] held;
        start_op(a, b, fun, sgn);
        chk({tag, ".busy_hi"}, busy, 1);
        cycles = 0;
        do begin
            @(posedge CLK_in);
            cycles++;
            #1;
        end while (!cmp_done && cycles < 20);
        if (!cmp_done) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout got=no_done exp=done", tag);
            return;
        end
        chk({tag, ".latency"}, cycles, e_lat);
        chk({tag, ".cmp_out"}, cmp_out, e_out);
        chk({tag, ".cmp_flag"}, cmp_flag, e_flag);
        chk({tag, ".sel_out"}, sel_out, e_sel);
        chk({tag, ".busy_lo"}, busy, 0);
        held = cmp_out;
        @(posedge CLK_in);
        #1;
        chk({tag, ".pulse_end"}, cmp_done, 0);
        chk({tag, ".hold"}, cmp_out, e_out);
    endtask

    initial begin
        int pulses;
        logic [1:0] cap_out;
        logic cap_flag;
        int lat;
        logic [1:0] m_out;
        logic m_flag;
        logic [15:0] m_sel;
        logic [15:0] ra, rb;
        logic [3:0] rf;
        logic rs;

        vecs[0] = '{16'h1234, 16'h1234, 4'b0001, 1'b0, 5, 2'b01, 1'b1, 16'h0000};
        vecs[1] = '{16'h0001, 16'hFFFF, 4'b0010, 1'b1, 2, 2'b10, 1'b1, 16'h0000};
        vecs[2] = '{16'h0001, 16'hFFFF, 4'b0010, 1'b0, 2, 2'b11, 1'b0, 16'h0000};
        vecs[3] = '{16'h8000, 16'h7FFF, 4'b0110, 1'b1, 2, 2'b11, 1'b0, 16'h7FFF};
        vecs[4] = '{16'h8000, 16'h7FFF, 4'b0111, 1'b1, 2, 2'b11, 1'b1, 16'h8000};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 4'b0100, 1'b1, 5, 2'b01, 1'b1, 16'h0000};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 4'b0101, 1'b1, 5, 2'b01, 1'b1, 16'h0000};
        vecs[7] = '{16'h0005, 16'h0003, 4'b0000, 1'b0, 1, 2'b00, 1'b0, 16'h0000};
        vecs[8] = '{16'h0001, 16'hFFFF, 4'b1010, 1'b1, 2, 2'b10, 1'b1, 16'h0000};
        vecs[9] = '{16'h00AB, 16'h00AB, 4'b0110, 1'b0, 5, 2'b01, 1'b1, 16'h00AB};

        RST_in = 1'b0; A_in = '0; B_in = '0; alu_fun = '0; signed_en = 1'b0; cmp_En = 1'b0;
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.cmp_done", cmp_done, 0);
        chk("reset.cmp_out", cmp_out, 0);
        chk("reset.cmp_flag", cmp_flag, 0);
        chk("reset.sel_out", sel_out, 0);
        repeat (3) @(negedge CLK_in);
        RST_in = 1'b1;

        for (int i = 0; i < 10; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].fun, vecs[i].sgn,
                      vecs[i].lat, vecs[i].out, vecs[i].flag, vecs[i].sel);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 2))
                0: rb = 16'($urandom);
                1: rb = ra;
                default: rb = ra ^ (16'h1 << $urandom_range(0, 15));
            endcase
            rf = 4'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rf[2:0], rs, lat, m_out, m_flag, m_sel);
            run_check($sformatf("rnd%0d", i), ra, rb, rf, rs, lat, m_out, m_flag, m_sel);
        end

        // Inputs and cmp_En toggled while scanning must not disturb the running compare.
        start_op(16'h1234, 16'h1234, 4'b0001, 1'b0);
        @(negedge CLK_in);
        A_in = 16'hFFFF; B_in = 16'h0000; alu_fun = 4'b0010; cmp_En = 1'b1;
        @(negedge CLK_in);
        cmp_En = 1'b0;
        pulses = 0; cap_out = 2'b00; cap_flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK_in);
            #1;
            if (cmp_done) begin
                pulses++;
                cap_out = cmp_out;
                cap_flag = cmp_flag;
            end
        end
        chk("midscan.pulses", pulses, 1);
        chk("midscan.cmp_out", cap_out, 2'b01);
        chk("midscan.cmp_flag", cap_flag, 1);

        // Reset mid-scan clears outputs at once and never produces a done pulse.
        start_op(16'h1234, 16'h1234, 4'b0001, 1'b0);
        @(posedge CLK_in);
        @(negedge CLK_in);
        RST_in = 1'b0;
        #1;
        chk("rstscan.busy", busy, 0);
        chk("rstscan.cmp_done", cmp_done, 0);
        chk("rstscan.cmp_out", cmp_out, 0);
        chk("rstscan.cmp_flag", cmp_flag, 0);
        chk("rstscan.sel_out", sel_out, 0);
        @(negedge CLK_in);
        RST_in = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK_in);
            #1;
            if (cmp_done) pulses++;
        end
        chk("rstscan.no_done", pulses, 0);
        run_check("after_rst_lt", 16'h0010, 16'h0020, 4'b0011, 1'b0, 4, 2'b11, 1'b1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
